// File: rtl/rtc_mmio.sv
// MMIO front-end for the rtc: TIME/ALARM/CTRL/STATUS registers plus background alarm polling.
// Optional registered alarm interrupt and CTRL.irq_mask are enabled by defining RTC_IRQ_EN.
`timescale 1ns/1ps
module rtc_mmio #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned POLL_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              rtc_ren,
    input  logic [63:0]       rtc_rdata,
    output logic              irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RTC_RD = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int unsigned     CNT_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] POLL_MAX = CNT_W'(POLL_CYCLES - 1);

    localparam logic [ADDR_W-1:0] OFF_TIME   = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] OFF_ALARM  = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(32'h18);

    state_t           state_q, state_d;
    logic             accept;
    logic             compare;
    logic             poll_fire;
    logic             match;
    logic [CNT_W-1:0] poll_cnt_q;
    logic [42:0]      alarm_q;
    logic             alarm_en_q;
    logic             pending_q;
    logic             last_match_q;
    logic             ctrl_bit1;
    logic             addr_hit;
    logic [63:0]      reg_rdata;
    logic             rd_time;
    logic             wr_alarm;
    logic             wr_ctrl;
    logic             wr_status;
    logic             unused_wdata;

    assign unused_wdata = ^req_wdata[63:43];
    assign match        = (rtc_rdata[42:0] == alarm_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        rtc_ren    = 1'b0;
        accept     = 1'b0;
        poll_fire  = 1'b0;
        compare    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (accept) begin
                    state_d = rd_time ? RTC_RD : RESP;
                end else if (poll_cnt_q == POLL_MAX) begin
                    poll_fire = 1'b1;
                    rtc_ren   = 1'b1;
                    compare   = 1'b1;
                end
            end
            RTC_RD: begin
                rtc_ren = 1'b1;
                compare = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_hit  = 1'b1;
        reg_rdata = '0;
        case (req_addr)
            OFF_TIME:   reg_rdata = '0;
            OFF_ALARM:  reg_rdata = {21'b0, alarm_q};
            OFF_CTRL:   reg_rdata = {62'b0, ctrl_bit1, alarm_en_q};
            OFF_STATUS: reg_rdata = {63'b0, pending_q};
            default:    addr_hit  = 1'b0;
        endcase
    end

    always_comb begin
        rd_time   = !req_wen && (req_addr == OFF_TIME);
        wr_alarm  = accept && req_wen && (req_addr == OFF_ALARM);
        wr_ctrl   = accept && req_wen && (req_addr == OFF_CTRL);
        wr_status = accept && req_wen && (req_addr == OFF_STATUS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            alarm_q      <= '0;
            alarm_en_q   <= 1'b0;
            pending_q    <= 1'b0;
            last_match_q <= 1'b0;
            poll_cnt_q   <= '0;
        end else begin
            if (accept) begin
                resp_rdata <= req_wen ? 64'd0 : reg_rdata;
                resp_err   <= !addr_hit;
            end
            if (state_q == RTC_RD) begin
                resp_rdata <= rtc_rdata;
                resp_err   <= 1'b0;
            end

            if (state_q == IDLE && !accept) begin
                if (poll_fire) begin
                    poll_cnt_q <= '0;
                end else begin
                    poll_cnt_q <= poll_cnt_q + CNT_W'(1);
                end
            end

            if (wr_alarm) begin
                alarm_q      <= req_wdata[42:0];
                last_match_q <= 1'b0;
            end
            if (wr_ctrl) begin
                alarm_en_q <= req_wdata[0];
            end

            // Set is placed after the W1C so a simultaneous set takes priority.
            if (wr_status && req_wdata[0]) begin
                pending_q <= 1'b0;
            end
            if (compare) begin
                last_match_q <= match;
                if (alarm_en_q && match && !last_match_q) begin
                    pending_q <= 1'b1;
                end
            end
        end
    end

`ifdef RTC_IRQ_EN
    logic irq_mask_q;
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_mask_q <= req_wdata[1];
            end
            irq_q <= pending_q && alarm_en_q;
        end
    end

    assign ctrl_bit1 = irq_mask_q;
    assign irq       = irq_q && !irq_mask_q;
`else
    assign ctrl_bit1 = 1'b0;
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_mmio.sv
// Scoreboard bench for rtc_mmio: driver queues expected responses, monitor pops and compares.
`timescale 1ns/1ps
module tb_rtc_mmio;

    localparam logic [63:0] S      = 64'h0000_07E5_1443_1105;
    localparam logic [63:0] AL_ALL = 64'h0000_07FF_FFFF_FFFF;
`ifdef RTC_IRQ_EN
    localparam logic        IRQ_ON = 1'b1;
`else
    localparam logic        IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b1;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [11:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        rtc_ren;
    logic [63:0] rtc_rdata;
    logic        irq;
    logic [63:0] stub = S;

    int checks = 0;
    int failures = 0;
    logic [64:0] exp_q[$];
    string       name_q[$];
    logic [64:0] mon_exp;
    string       mon_name;

    rtc_mmio #(.ADDR_W(12), .POLL_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .rtc_ren(rtc_ren), .rtc_rdata(rtc_rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    assign rtc_rdata = rtc_ren ? stub : 64'h0BAD_CAFE_0BAD_CAFE;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b expected no response",
                         resp_rdata, resp_err);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                chk({mon_name, "_rdata"}, resp_rdata, mon_exp[63:0]);
                chk({mon_name, "_err"}, {63'b0, resp_err}, {63'b0, mon_exp[64]});
            end
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        if (!req_ready) chk({name, "_idle_timeout"}, {63'b0, req_ready}, 64'd1);
    endtask

    task automatic issue(input logic wen, input logic [11:0] addr, input logic [63:0] wdata,
                         input logic [63:0] er, input logic ee, input string name);
        wait_idle(name);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        exp_q.push_back({ee, er});
        name_q.push_back(name);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wen   = 1'b0;
    endtask

    task automatic access(input logic wen, input logic [11:0] addr, input logic [63:0] wdata,
                          input logic [63:0] er, input logic ee, input string name);
        issue(wen, addr, wdata, er, ee, name);
        wait_idle(name);
    endtask

    task automatic wait_poll(input string name);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rtc_ren) break;
        end
        chk(name, {63'b0, rtc_ren}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with req_valid held high
        @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {61'b0, req_ready, resp_valid, irq}, 64'b100);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        chk("rst_outputs2", {61'b0, req_ready, resp_valid, irq}, 64'b100);
        chk("rst_rdata", resp_rdata, 64'd0);
        access(1'b0, 12'h008, '0, 64'd0, 1'b0, "rst_alarm");
        access(1'b0, 12'h010, '0, 64'd0, 1'b0, "rst_ctrl");
        access(1'b0, 12'h018, '0, 64'd0, 1'b0, "rst_status");

        // TIME read: strobe one cycle after accept, response the cycle after
        issue(1'b0, 12'h000, '0, S, 1'b0, "time_rd");
        chk("time_ren_cycle1", {62'b0, rtc_ren, resp_valid}, 64'b10);
        @(negedge clk);
        chk("time_ren_cycle2", {62'b0, rtc_ren, resp_valid}, 64'b01);
        wait_idle("time_rd");

        // ALARM width masking and response hold under backpressure
        access(1'b1, 12'h008, '1, 64'd0, 1'b0, "alarm_wr");
        resp_ready = 1'b0;
        issue(1'b0, 12'h008, '0, AL_ALL, 1'b0, "alarm_rd_hold");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("hold_valid_ready", {62'b0, resp_valid, req_ready}, 64'b10);
            chk("hold_rdata", resp_rdata, AL_ALL);
        end
        resp_ready = 1'b1;
        wait_idle("alarm_rd_hold");

        // alarm fire
        access(1'b1, 12'h010, 64'd1, 64'd0, 1'b0, "ctrl_en");
        access(1'b1, 12'h008, S, 64'd0, 1'b0, "alarm_set");
        wait_poll("fire_poll");
        @(negedge clk);
        chk("irq_before", {63'b0, irq}, 64'd0);
        @(negedge clk);
        chk("irq_after", {63'b0, irq}, {63'b0, IRQ_ON});
        access(1'b0, 12'h018, '0, 64'd1, 1'b0, "status_fired");
        access(1'b1, 12'h018, 64'd1, 64'd0, 1'b0, "w1c");
        access(1'b0, 12'h018, '0, 64'd0, 1'b0, "status_cleared");
        repeat (12) @(negedge clk);
        access(1'b0, 12'h018, '0, 64'd0, 1'b0, "status_no_rearm");
        chk("irq_cleared", {63'b0, irq}, 64'd0);
        stub = S ^ 64'd1;
        repeat (12) @(negedge clk);
        stub = S;
        repeat (12) @(negedge clk);
        access(1'b0, 12'h018, '0, 64'd1, 1'b0, "status_rearmed");

        // mask bit and alarm_en independence from pending
        access(1'b1, 12'h010, 64'd3, 64'd0, 1'b0, "ctrl_mask");
        repeat (3) @(negedge clk);
        chk("irq_masked", {63'b0, irq}, 64'd0);
        access(1'b0, 12'h010, '0, IRQ_ON ? 64'd3 : 64'd1, 1'b0, "ctrl_rd_mask");
        access(1'b1, 12'h010, 64'd0, 64'd0, 1'b0, "ctrl_dis");
        access(1'b0, 12'h018, '0, 64'd1, 1'b0, "pending_kept");
        access(1'b1, 12'h010, 64'd1, 64'd0, 1'b0, "ctrl_reen");
        repeat (3) @(negedge clk);
        chk("irq_reen", {63'b0, irq}, {63'b0, IRQ_ON});

        // unmapped offsets
        access(1'b0, 12'h020, '0, 64'd0, 1'b1, "unmapped_rd");
        access(1'b1, 12'h028, '1, 64'd0, 1'b1, "unmapped_wr");
        access(1'b0, 12'h008, '0, S, 1'b0, "alarm_intact");
        access(1'b0, 12'h010, '0, 64'd1, 1'b0, "ctrl_intact");

        // W1C accepted on the matching poll cycle: deferred poll sets again
        stub = S ^ 64'd1;
        wait_poll("race_poll_a");
        @(negedge clk);
        stub = S;
        repeat (3) @(negedge clk);
        chk("poll_period", {63'b0, rtc_ren}, 64'd1);
        issue(1'b1, 12'h018, 64'd1, 64'd0, 1'b0, "race_w1c");
        wait_idle("race_w1c");
        repeat (3) @(negedge clk);
        access(1'b0, 12'h018, '0, 64'd1, 1'b0, "race_status");

        // reset during RTC_RD
        issue(1'b0, 12'h000, '0, S, 1'b0, "abort_time");
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rtcrd", {62'b0, resp_valid, req_ready}, 64'b01);
        rst = 1'b0;
        exp_q.delete();
        name_q.delete();

        // reset during RESP
        resp_ready = 1'b0;
        issue(1'b0, 12'h018, '0, 64'd0, 1'b0, "abort_resp");
        rst = 1'b1;
        @(negedge clk);
        chk("abort_resp_state", {62'b0, resp_valid, req_ready}, 64'b01);
        rst = 1'b0;
        exp_q.delete();
        name_q.delete();
        resp_ready = 1'b1;
        access(1'b0, 12'h008, '0, 64'd0, 1'b0, "post_rst_alarm");
        access(1'b0, 12'h018, '0, 64'd0, 1'b0, "post_rst_status");
        access(1'b0, 12'h010, '0, 64'd0, 1'b0, "post_rst_ctrl");
        access(1'b0, 12'h000, '0, S, 1'b0, "post_rst_time");
        chk("post_rst_irq", {63'b0, irq}, 64'd0);

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL pending_responses: got %0d outstanding expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
